obi_mem_responder: RTL

//  Memory-side OBI responder: the far end of the CPU's fetch/load-store OBI ports.

---
 rtl/obi_mem_responder_if.sv | 15 +
 rtl/obi_mem_responder.sv | 54 +++++
 2 files changed

// File: rtl/obi_mem_responder_if.sv
// obi_mem_responder_if: OBI request/response bundle between an initiator and a memory responder
// proc_req/addr/wdata/web : request from initiator (web = 0 write, 1 read)
// rdy                     : grant, request accepted when proc_req && rdy at rising edge
// rdata/valid             : in-order response, one cycle per accepted request
interface obi_mem_responder_if;
  logic        proc_req;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        web;
  logic        rdy;
  logic [31:0] rdata;
  logic        valid;
  modport master (output proc_req, addr, wdata, web, input rdy, rdata, valid);
  modport slave (input proc_req, addr, wdata, web, output rdy, rdata, valid);
endinterface

// File: rtl/obi_mem_responder.sv
// obi_mem_responder: OBI memory-side responder with fixed-latency in-order responses and programmable back-pressure
// clk : rising-edge clock
// rst : asynchronous active-low reset
// bus : OBI slave port (proc_req/addr/wdata/web in, rdy/rdata/valid out)
module obi_mem_responder #(
  parameter int    ADDR_W          = 10,
  parameter int    LATENCY         = 1,
  parameter int    MAX_OUTSTANDING = 1,
  parameter int    STALL_PERIOD    = 0,
  parameter string INIT_FILE       = ""
) (
  input logic               clk,
  input logic               rst,
  obi_mem_responder_if.slave bus
);
  localparam int SW = STALL_PERIOD > 1 ? $clog2(STALL_PERIOD) : 1;
  logic [31:0]       mem [2**ADDR_W];
  logic              pv [LATENCY];
  logic [31:0]       pd [LATENCY];
  logic [3:0]        outst;
  logic [SW-1:0]     scnt;
  logic              stall, acc, oor;
  logic [ADDR_W-1:0] idx;
  assign idx   = bus.addr[ADDR_W+1:2];
  assign oor   = |bus.addr[31:ADDR_W+2];
  assign stall = STALL_PERIOD > 1 && scnt == SW'(STALL_PERIOD - 1);
  // A response leaving this cycle frees a slot, so the limit can be met while still granting.
  // Gating with rst keeps rdy low for the whole reset, not just after the next edge.
  assign bus.rdy   = rst && !stall && (outst < 4'(MAX_OUTSTANDING) || pv[LATENCY-1]);
  assign acc       = bus.proc_req && bus.rdy;
  assign bus.valid = pv[LATENCY-1];
  assign bus.rdata = pd[LATENCY-1];
  // Array has no reset so contents survive rst; acc is already low during reset.
  always_ff @(posedge clk)
    if (acc && !bus.web && !oor) mem[idx] <= bus.wdata;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        pv[i] <= 1'b0;
        pd[i] <= '0;
      end
      outst <= '0;
      scnt  <= '0;
    end else begin
      pv[0] <= acc;
      pd[0] <= !acc || !bus.web ? 32'h0 : oor ? 32'h0BAD_ADD0 : mem[idx];
      for (int i = 1; i < LATENCY; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
      outst <= outst + 4'(acc) - 4'(pv[LATENCY-1]);
      scnt  <= stall || STALL_PERIOD < 2 ? '0 : scnt + 1'b1;
    end
endmodule
